spi3w_target: RTL



---
 rtl/spi3w_pkg.sv | 42 ++++
 rtl/spi3w_target_if.sv | 35 +++
 rtl/spi3w_regfile.sv | 91 +++++++++
 rtl/spi3w_target.sv | 123 ++++++++++++
 4 files changed

// File: rtl/spi3w_pkg.sv
// spi3w_pkg: constants and helpers shared by the 3-wire SPI blocks
// (target, 4-to-3-wire converter, future SPI peripherals).
//   - Transaction framing: 16-bit instruction followed by 8 data bits.
//   - Transaction bit k is the k-th bit on the wire (bit 0 first, MSB first).
//   - decode_instr() turns the 16 shifted-in instruction bits into fields.
package spi3w_pkg;

    localparam int INSTR_BITS = 16;
    localparam int DATA_BITS  = 8;
    localparam int TXN_BITS   = 24;
    localparam int ADDR_BITS  = 13;
    localparam int CNT_BITS   = 5;

    // Positions in transaction-bit numbering (bit 0 is sent first).
    localparam int RW_POS   = 0;
    localparam int LEN_LSB  = 1;
    localparam int LEN_BITS = 2;

    typedef enum logic {
        RW_WRITE = 1'b0,
        RW_READ  = 1'b1
    } rw_e;

    localparam logic [LEN_BITS-1:0] LEN_SINGLE = 2'b00;

    typedef struct packed {
        rw_e                  rw;
        logic [LEN_BITS-1:0]  len;
        logic [ADDR_BITS-1:0] addr;
    } instr_t;

    // The instruction word is assembled MSB first, so transaction bit k
    // lands at word index INSTR_BITS-1-k.
    function automatic instr_t decode_instr(input logic [INSTR_BITS-1:0] w);
        instr_t d;
        d.rw   = rw_e'(w[INSTR_BITS-1-RW_POS]);
        d.len  = {w[INSTR_BITS-1-LEN_LSB], w[INSTR_BITS-2-LEN_LSB]};
        d.addr = w[ADDR_BITS-1:0];
        return d;
    endfunction

endpackage

// File: rtl/spi3w_target_if.sv
// spi3w_target_if: chip select plus the register-side outputs of the
// 3-wire SPI target, and debug visibility of its bit counter and Sdio
// output enable. The shared Sdio wire is a plain inout on the target.
//
// Framing: a transaction is the period with Cs_f low. The target samples
// Sdio on every rising Sclk edge; a write takes effect only when all 24
// bits arrive before Cs_f rises, and the commit is announced by
// wr_toggle changing, after which regs_flat and wr_addr are stable until
// the next toggle. Cs_f high aborts the transaction at once.
//
// Ports (slave view): Cs_f in; regs_flat, wr_toggle, wr_addr,
// dbg_rcnt, dbg_oe out.
interface spi3w_target_if #(
    parameter int NREG = 8
);
    import spi3w_pkg::*;

    logic                  Cs_f;
    logic [8*NREG-1:0]     regs_flat;
    logic                  wr_toggle;
    logic [3:0]            wr_addr;
    logic [CNT_BITS-1:0]   dbg_rcnt;
    logic                  dbg_oe;

    modport master (
        output Cs_f,
        input  regs_flat, wr_toggle, wr_addr, dbg_rcnt, dbg_oe
    );

    modport slave (
        input  Cs_f,
        output regs_flat, wr_toggle, wr_addr, dbg_rcnt, dbg_oe
    );

endinterface

// File: rtl/spi3w_regfile.sv
// spi3w_regfile: NREG byte registers with the write port and read decode.
// Ports:
//   Sclk, resetn       clock (gated SPI clock) and async active-low reset
//   wr_req_i           complete, well-formed single-byte write this edge
//   addr_i             13-bit instruction address (read and write)
//   wr_data_i          byte to write
//   rd_data_o          register / ID / zero, depending on addr_i
//   regs_flat_o        register i at bits [8i+7:8i]
//   wr_toggle_o        inverts on each committed write
//   wr_addr_o          address of the last committed write
module spi3w_regfile
    import spi3w_pkg::*;
#(
    parameter int             NREG      = 8,
    parameter logic [7:0]     RESET_VAL = 8'h00,
    parameter logic [12:0]    ID_ADDR   = 13'h1FFF,
    parameter logic [7:0]     ID_VALUE  = 8'hA5
) (
    input  logic                 Sclk,
    input  logic                 resetn,
    input  logic                 wr_req_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [7:0]           wr_data_i,
    output logic [7:0]           rd_data_o,
    output logic [8*NREG-1:0]    regs_flat_o,
    output logic                 wr_toggle_o,
    output logic [3:0]           wr_addr_o
);

    logic [7:0] regs_q [NREG];
    logic [7:0] regs_d [NREG];
    logic       wr_toggle_q, wr_toggle_d;
    logic [3:0] wr_addr_q, wr_addr_d;
    logic       in_range;

    assign in_range = (addr_i < ADDR_BITS'(NREG));

    // Out-of-range and ID-address writes fall through with no side effect.
    always_comb begin
        regs_d      = regs_q;
        wr_toggle_d = wr_toggle_q;
        wr_addr_d   = wr_addr_q;
        if (wr_req_i && in_range) begin
            for (int i = 0; i < NREG; i++) begin
                if (addr_i == ADDR_BITS'(i)) begin
                    regs_d[i] = wr_data_i;
                end
            end
            wr_toggle_d = ~wr_toggle_q;
            wr_addr_d   = addr_i[3:0];
        end
    end

    always_ff @(posedge Sclk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= RESET_VAL;
            end
            wr_toggle_q <= 1'b0;
            wr_addr_q   <= 4'd0;
        end else begin
            regs_q      <= regs_d;
            wr_toggle_q <= wr_toggle_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    // A real register wins over the ID if the two addresses ever overlap.
    always_comb begin
        rd_data_o = 8'h00;
        if (addr_i == ID_ADDR) begin
            rd_data_o = ID_VALUE;
        end
        for (int i = 0; i < NREG; i++) begin
            if (addr_i == ADDR_BITS'(i)) begin
                rd_data_o = regs_q[i];
            end
        end
    end

    always_comb begin
        regs_flat_o = '0;
        for (int i = 0; i < NREG; i++) begin
            regs_flat_o[8*i +: 8] = regs_q[i];
        end
    end

    assign wr_toggle_o = wr_toggle_q;
    assign wr_addr_o   = wr_addr_q;

endmodule

// File: rtl/spi3w_target.sv
// spi3w_target: 3-wire SPI target (shared Sdio) with a byte register file.
// Ports:
//   Sclk    gated SPI clock, idle low; master changes data on falling edges
//   resetn  async active-low power-on reset
//   Sdio    shared serial data, MSB first
//   bus     Cs_f in; regs_flat / wr_toggle / wr_addr / debug out
// Holds the bit counter, the input shift register, the latched
// instruction and the Sdio read driver.
module spi3w_target
    import spi3w_pkg::*;
#(
    parameter int          NREG      = 8,
    parameter logic [7:0]  RESET_VAL = 8'h00,
    parameter logic [12:0] ID_ADDR   = 13'h1FFF,
    parameter logic [7:0]  ID_VALUE  = 8'hA5
) (
    input  logic             Sclk,
    input  logic             resetn,
    inout  wire              Sdio,
    spi3w_target_if.slave    bus
);

    localparam logic [CNT_BITS-1:0] CNT_INSTR_LAST = CNT_BITS'(INSTR_BITS - 1);
    localparam logic [CNT_BITS-1:0] CNT_DATA_FIRST = CNT_BITS'(INSTR_BITS);
    localparam logic [CNT_BITS-1:0] CNT_TXN_LAST   = CNT_BITS'(TXN_BITS - 1);
    localparam logic [CNT_BITS-1:0] CNT_TXN_DONE   = CNT_BITS'(TXN_BITS);

    // Transaction-scoped state is cleared by either reset or deselect.
    logic txn_clr_n;
    assign txn_clr_n = resetn & ~bus.Cs_f;

    logic [CNT_BITS-1:0]   rcnt_q, rcnt_d;
    logic [INSTR_BITS-2:0] shift_q, shift_d;
    instr_t                instr_q, instr_d;
    logic                  oe_q, oe_d;
    logic [7:0]            tx_q, tx_d;

    logic                  wr_req;
    logic [7:0]            wr_data;
    logic [7:0]            rd_data;
    logic                  instr_ok;

    // ---------------- receive side (rising edges) ----------------
    always_comb begin
        rcnt_d  = rcnt_q;
        shift_d = shift_q;
        instr_d = instr_q;
        if (rcnt_q < CNT_TXN_DONE) begin
            rcnt_d  = rcnt_q + 1'b1;
            shift_d = {shift_q[INSTR_BITS-3:0], Sdio};
            if (rcnt_q == CNT_INSTR_LAST) begin
                instr_d = decode_instr({shift_q, Sdio});
            end
        end
    end

    always_ff @(posedge Sclk or negedge txn_clr_n) begin
        if (!txn_clr_n) begin
            rcnt_q  <= '0;
            shift_q <= '0;
            instr_q <= '0;
        end else begin
            rcnt_q  <= rcnt_d;
            shift_q <= shift_d;
            instr_q <= instr_d;
        end
    end

    assign instr_ok = (instr_q.len == LEN_SINGLE);

    // Last data bit is still on Sdio at the commit edge.
    assign wr_data = {shift_q[6:0], Sdio};
    assign wr_req  = (rcnt_q == CNT_TXN_LAST) && instr_ok && (instr_q.rw == RW_WRITE);

    spi3w_regfile #(
        .NREG      (NREG),
        .RESET_VAL (RESET_VAL),
        .ID_ADDR   (ID_ADDR),
        .ID_VALUE  (ID_VALUE)
    ) u_regfile (
        .Sclk        (Sclk),
        .resetn      (resetn),
        .wr_req_i    (wr_req),
        .addr_i      (instr_q.addr),
        .wr_data_i   (wr_data),
        .rd_data_o   (rd_data),
        .regs_flat_o (bus.regs_flat),
        .wr_toggle_o (bus.wr_toggle),
        .wr_addr_o   (bus.wr_addr)
    );

    // ---------------- transmit side (falling edges) ----------------
    // A malformed length field still occupies the data phase, driving zeros,
    // so the master's turnaround timing is the same for every read.
    always_comb begin
        oe_d = oe_q;
        tx_d = tx_q;
        if (rcnt_q == CNT_DATA_FIRST && instr_q.rw == RW_READ) begin
            oe_d = 1'b1;
            tx_d = instr_ok ? rd_data : 8'h00;
        end else if (rcnt_q == CNT_TXN_DONE) begin
            oe_d = 1'b0;
        end else if (oe_q) begin
            tx_d = {tx_q[6:0], 1'b0};
        end
    end

    always_ff @(negedge Sclk or negedge txn_clr_n) begin
        if (!txn_clr_n) begin
            oe_q <= 1'b0;
            tx_q <= 8'h00;
        end else begin
            oe_q <= oe_d;
            tx_q <= tx_d;
        end
    end

    assign Sdio = oe_q ? tx_q[7] : 1'bz;

    assign bus.dbg_rcnt = rcnt_q;
    assign bus.dbg_oe   = oe_q;

endmodule
